regfile_test_driver: RTL

Self-checking stimulus engine for the regfile test port of the processor test harness. It drives the harness `test` select and the `t_ctrl_*` / `t_data_writeReg` inputs. It writes a deterministic pattern into every register, reads all 32 back through both read ports, and compares the results. It sits beside the harness as the driving end of the test mux: it produces what the harness consumes, and it consumes `t_data_readRegA` / `t_data_readRegB`.

---
 rtl/regfile_test_pkg.sv | 22 ++
 rtl/regfile_pattern_gen.sv | 22 ++
 rtl/regfile_test_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/regfile_test_pkg.sv
// Shared types and constants for the regfile self-test driver.
// Provides the FSM state enum, pattern step and per-pass cycle count.
package regfile_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int NUM_REGS = 32;
  localparam logic [31:0] PAT_STEP = 32'h0101_0101;

  // Cycles spent in one write-then-verify pass over all registers.
  function automatic int pass_cycles(input int read_lat);
    return (NUM_REGS - 1) + NUM_REGS * (2 + read_lat);
  endfunction

endpackage

// File: rtl/regfile_pattern_gen.sv
// Combinational pattern source: (pass, reg) -> expected register value.
// Ports: pass_sel, reg_idx in; value out (0 for reg 0, pattern otherwise).
module regfile_pattern_gen
  import regfile_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hA5A5_0000
) (
  input  logic        pass_sel,
  input  logic [4:0]  reg_idx,
  output logic [31:0] value
);

  logic [31:0] base;
  logic [31:0] pat;

  assign base  = pass_sel ? ~SEED : SEED;
  assign pat   = base + {27'd0, reg_idx} * PAT_STEP;
  // Reg 0 reads as zero; writes never target it, so this
  // value doubles as the write data.
  assign value = (reg_idx == 5'd0) ? 32'd0 : pat;

endmodule

// File: rtl/regfile_test_driver.sv
// Regfile self-test engine: writes two pattern passes, reads back on both ports.
// Ports: clock/reset/start in, t_ctrl_*/t_data_writeReg/test out, read data in,
// busy/done/pass/fail_count/first_fail_reg status out.
module regfile_test_driver
  import regfile_test_pkg::*;
#(
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
  parameter int          READ_LAT     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  output logic [4:0]  t_ctrl_readRegB,
  output logic [31:0] t_data_writeReg,
  input  logic [31:0] t_data_readRegA,
  input  logic [31:0] t_data_readRegB,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [4:0]  first_fail_reg
);

  localparam logic [2:0] WAIT_LAST =
    3'(READ_LAT > 0 ? READ_LAT - 1 : 0);
  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_t      state;
  state_t      state_nx;
  logic        pass_q;
  logic [4:0]  reg_q;
  logic [2:0]  wait_q;
  logic [5:0]  fails_q;
  logic [4:0]  first_q;
  logic [4:0]  reg_b;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        mis_a;
  logic        mis_b;
  logic        last_reg;

  assign reg_b    = LAST_REG - reg_q;
  assign last_reg = (reg_q == LAST_REG);
  assign mis_a    = (t_data_readRegA != exp_a);
  assign mis_b    = (t_data_readRegB != exp_b);

  // Port A instance also supplies write data (reg_q >= 1 in WRITE).
  regfile_pattern_gen #(.SEED(PATTERN_SEED)) u_gen_a (
    .pass_sel (pass_q),
    .reg_idx  (reg_q),
    .value    (exp_a)
  );

  regfile_pattern_gen #(.SEED(PATTERN_SEED)) u_gen_b (
    .pass_sel (pass_q),
    .reg_idx  (reg_b),
    .value    (exp_b)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_WRITE;
      S_WRITE:        if (last_reg) state_nx = S_READ;
      S_READ:         state_nx = (READ_LAT == 0) ? S_CHECK : S_WAIT;
      S_WAIT:         if (wait_q == WAIT_LAST) state_nx = S_CHECK;
      S_CHECK: begin
        if (!last_reg)  state_nx = S_READ;
        else if (pass_q) state_nx = S_DONE;
        else             state_nx = S_WRITE;
      end
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_q  <= 1'b0;
      reg_q   <= 5'd0;
      wait_q  <= 3'd0;
      fails_q <= 6'd0;
      first_q <= 5'd0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass_q  <= 1'b0;
            reg_q   <= 5'd1;
            wait_q  <= 3'd0;
            fails_q <= 6'd0;
            first_q <= 5'd0;
          end
        end
        S_WRITE: reg_q <= last_reg ? 5'd0 : reg_q + 5'd1;
        S_READ:  wait_q <= 3'd0;
        S_WAIT:  wait_q <= wait_q + 3'd1;
        S_CHECK: begin
          if (mis_a || mis_b) begin
            if (fails_q == 6'd0) first_q <= mis_a ? reg_q : reg_b;
            if (fails_q != 6'd63) fails_q <= fails_q + 6'd1;
          end
          if (last_reg && !pass_q) begin
            pass_q <= 1'b1;
            reg_q  <= 5'd1;
          end else begin
            reg_q <= reg_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    test               = 1'b0;
    busy               = 1'b0;
    t_ctrl_writeEnable = 1'b0;
    t_ctrl_writeReg    = 5'd0;
    t_ctrl_readRegA    = 5'd0;
    t_ctrl_readRegB    = 5'd0;
    t_data_writeReg    = 32'd0;
    done               = 1'b0;
    unique case (state)
      S_WRITE: begin
        test               = 1'b1;
        busy               = 1'b1;
        t_ctrl_writeEnable = 1'b1;
        t_ctrl_writeReg    = reg_q;
        t_data_writeReg    = exp_a;
      end
      S_READ, S_WAIT, S_CHECK: begin
        test            = 1'b1;
        busy            = 1'b1;
        t_ctrl_readRegA = reg_q;
        t_ctrl_readRegB = reg_b;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass           = done && (fails_q == 6'd0);
  assign fail_count     = fails_q;
  assign first_fail_reg = first_q;

endmodule
